// File: rtl/keccak_absorb_loader.sv
// Keccak absorb loader: header/message word stream to padded rate blocks,
// queued through a small in-order block buffer.
module keccak_absorb_loader #(
    parameter int W        = 64,
    parameter int NUM_BUFS = 2,
    parameter int RATE_MAX = 1344
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [W-1:0]             s_data,
    input  logic                     s_last,
    input  logic [$clog2(W/8):0]     s_keep,
    output logic                     blk_valid,
    input  logic                     blk_ready,
    output logic [RATE_MAX-1:0]      blk_data,
    output logic                     blk_last,
    output logic [1:0]               blk_mode,
    output logic [31:0]              blk_out_size,
    output logic                     busy
);
    localparam int BPW = W / 8;
    localparam int KW  = $clog2(BPW) + 1;
    localparam int HW  = 64 / W;
    localparam int PW  = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
    localparam int DW  = $clog2(RATE_MAX);

    typedef enum logic [1:0] {S_HDR, S_DATA, S_PAD} state_t;

    state_t              state;
    logic                run;
    logic                hcnt;
    logic                pad2;
    logic [5:0]          idx;
    logic [KW-1:0]       kq;
    logic [1:0]          cur_mode;
    logic [31:0]         cur_osize;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [RATE_MAX-1:0] slot_data [NUM_BUFS];
    logic [NUM_BUFS-1:0] slot_full;
    logic [NUM_BUFS-1:0] slot_last;
    logic [1:0]          slot_mode [NUM_BUFS];
    logic [31:0]         slot_osize [NUM_BUFS];

    logic [7:0]          rate_b;
    logic [7:0]          dom;
    logic [5:0]          rate_w;
    logic [KW-1:0]       k;
    logic [W-1:0]        wd;
    logic [7:0]          p;
    logic [7:0]          pp;
    logic [DW-1:0]       wbit;
    logic [RATE_MAX-1:0] pv;
    logic                wr_full;
    logic                acc;
    logic                pop;
    logic                commit;
    logic                commit_last;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] ptr);
        return (ptr == PW'(NUM_BUFS - 1)) ? '0 : ptr + PW'(1);
    endfunction

    always_comb begin
        unique case (cur_mode)
            2'd0:    begin rate_b = 8'd168; dom = 8'h1F; end
            2'd1:    begin rate_b = 8'd136; dom = 8'h1F; end
            2'd2:    begin rate_b = 8'd136; dom = 8'h06; end
            default: begin rate_b = 8'd72;  dom = 8'h06; end
        endcase
        rate_w = 6'(int'(rate_b) * 8 / W);
    end

    // Last word keeps only its first k bytes; the rest become padding space.
    always_comb begin
        k  = (s_keep > KW'(BPW)) ? KW'(BPW) : s_keep;
        wd = '0;
        for (int b = 0; b < BPW; b++)
            wd[b*8 +: 8] = (!s_last || b < int'(k)) ? s_data[b*8 +: 8] : 8'h00;
        wbit = DW'(int'(idx) * W);
    end

    always_comb begin
        p  = 8'(int'(idx) * BPW + int'(kq));
        pp = pad2 ? 8'd0 : p;
        pv = '0;
        if (pp < rate_b)
            pv[DW'({pp, 3'b000}) +: 8] = dom;
        pv[DW'((int'(rate_b) - 1) * 8) +: 8] =
            pv[DW'((int'(rate_b) - 1) * 8) +: 8] | 8'h80;
    end

    assign wr_full = slot_full[wr_ptr];
    assign s_ready = run & ((state == S_HDR) || (state == S_DATA && !wr_full));
    assign acc     = s_valid & s_ready;
    assign pop     = slot_full[rd_ptr] & blk_ready;

    assign commit_last = (state == S_PAD) && (pad2 || p < rate_b);
    assign commit = (state == S_DATA && acc && !s_last && idx == rate_w - 6'd1)
                 || (state == S_PAD && (!pad2 || !wr_full));

    assign blk_valid    = slot_full[rd_ptr];
    assign blk_data     = slot_data[rd_ptr];
    assign blk_last     = slot_last[rd_ptr];
    assign blk_mode     = slot_mode[rd_ptr];
    assign blk_out_size = slot_osize[rd_ptr];
    assign busy         = (state != S_HDR) || (|slot_full);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_HDR;
            run       <= 1'b0;
            hcnt      <= 1'b0;
            pad2      <= 1'b0;
            idx       <= '0;
            kq        <= '0;
            cur_mode  <= '0;
            cur_osize <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            slot_full <= '0;
            slot_last <= '0;
            for (int i = 0; i < NUM_BUFS; i++) begin
                slot_data[i]  <= '0;
                slot_mode[i]  <= '0;
                slot_osize[i] <= '0;
            end
        end else begin
            run <= 1'b1;
            if (pop) begin
                slot_data[rd_ptr]  <= '0;
                slot_full[rd_ptr]  <= 1'b0;
                slot_last[rd_ptr]  <= 1'b0;
                slot_mode[rd_ptr]  <= '0;
                slot_osize[rd_ptr] <= '0;
                rd_ptr             <= nxt(rd_ptr);
            end
            if (commit) begin
                slot_full[wr_ptr]  <= 1'b1;
                slot_last[wr_ptr]  <= commit_last;
                slot_mode[wr_ptr]  <= cur_mode;
                slot_osize[wr_ptr] <= cur_osize;
                wr_ptr             <= nxt(wr_ptr);
            end
            if (commit && commit_last)
                slot_data[wr_ptr] <= slot_data[wr_ptr] | pv;
            unique case (state)
                S_HDR: if (acc) begin
                    if (!hcnt)
                        cur_mode <= s_data[1:0];
                    if (HW == 1 || hcnt) begin
                        cur_osize <= s_data[W-1:W-32];
                        hcnt      <= 1'b0;
                        idx       <= '0;
                        state     <= S_DATA;
                    end else begin
                        hcnt <= 1'b1;
                    end
                end
                S_DATA: if (acc) begin
                    slot_data[wr_ptr][wbit +: W] <= wd;
                    if (s_last) begin
                        kq    <= k;
                        state <= S_PAD;
                    end else if (idx == rate_w - 6'd1) begin
                        idx <= '0;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                S_PAD: if (!pad2) begin
                    if (commit_last) state <= S_HDR;
                    else             pad2  <= 1'b1;
                end else if (!wr_full) begin
                    pad2  <= 1'b0;
                    state <= S_HDR;
                end
                default: state <= S_HDR;
            endcase
        end
    end
endmodule

// File: tb/tb_keccak_absorb_loader.sv
// Directed bench for keccak_absorb_loader (W=64, NUM_BUFS=2) with
// hand-computed block images checked by immediate assertions.
module tb_keccak_absorb_loader;
    typedef logic [1343:0] blk_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] s_data = '0;
    logic        s_last = 1'b0;
    logic [3:0]  s_keep = '0;
    logic        blk_valid;
    logic        blk_ready = 1'b0;
    blk_t        blk_data;
    logic        blk_last;
    logic [1:0]  blk_mode;
    logic [31:0] blk_out_size;
    logic        busy;

    int checks = 0;
    int failures = 0;
    blk_t e;

    always #5 clk = ~clk;

    keccak_absorb_loader #(.W(64), .NUM_BUFS(2), .RATE_MAX(1344)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .s_keep(s_keep),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_last(blk_last), .blk_mode(blk_mode),
        .blk_out_size(blk_out_size), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_data(input string tag, input blk_t exp);
        int bi = 0;
        for (int i = 1343 / 8; i >= 0; i--)
            if (blk_data[i*8 +: 8] !== exp[i*8 +: 8]) bi = i;
        checks++;
        assert (blk_data === exp) else begin
            failures++;
            $error("FAIL %s: byte %0d got %02h expected %02h",
                   tag, bi, blk_data[bi*8 +: 8], exp[bi*8 +: 8]);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [1:0] m,
                                        input logic [31:0] o);
        return {o, 30'd0, m};
    endfunction

    task automatic send(input string tag, input logic [63:0] d,
                        input logic l, input logic [3:0] kp);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        s_keep  = kp;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk({tag, "_timeout"}, 64'(s_ready), 64'd1);
        else begin
            @(posedge clk);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_keep  = '0;
    endtask

    task automatic get_blk(input string tag, input blk_t exp,
                           input logic l, input logic [1:0] m,
                           input logic [31:0] o);
        int n = 0;
        while (!blk_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 64'(blk_valid), 64'd1);
        chk_data({tag, "_data"}, exp);
        chk({tag, "_last"}, 64'(blk_last), 64'(l));
        chk({tag, "_mode"}, 64'(blk_mode), 64'(m));
        chk({tag, "_osize"}, 64'(blk_out_size), 64'(o));
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_blk_valid", 64'(blk_valid), 64'd0);
        chk("rst_blk_last", 64'(blk_last), 64'd0);
        chk("rst_blk_mode", 64'(blk_mode), 64'd0);
        chk("rst_osize", 64'(blk_out_size), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("hdr_ready", 64'(s_ready), 64'd1);

        // Empty SHAKE128 message, including the two-cycle latency.
        send("t1_h", hdr(2'd0, 32'd256), 1'b0, 4'd0);
        send("t1_d", 64'd0, 1'b1, 4'd0);
        chk("t1_pad_cycle", 64'(blk_valid), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t1_lat", 64'(blk_valid), 64'd1);
        e = '0;
        e[7:0] = 8'h1F;
        e[167*8 +: 8] = 8'h80;
        get_blk("t1", e, 1'b1, 2'd0, 32'd256);
        chk("t1_idle", 64'(busy), 64'd0);

        // SHA3-512 exactly one rate of data: extra padding block.
        send("t2_h", hdr(2'd3, 32'd512), 1'b0, 4'd0);
        e = '0;
        for (int i = 0; i < 9; i++) begin
            e[i*64 +: 64] = 64'h0123456789ABCDEF + 64'(i);
            send("t2_d", 64'h0123456789ABCDEF + 64'(i), i == 8, 4'd8);
        end
        get_blk("t2a", e, 1'b0, 2'd3, 32'd512);
        e = '0;
        e[7:0] = 8'h06;
        e[71*8 +: 8] = 8'h80;
        get_blk("t2b", e, 1'b1, 2'd3, 32'd512);

        // SHA3-256 with the domain byte landing on the final rate byte.
        send("t3_h", hdr(2'd2, 32'd256), 1'b0, 4'd0);
        e = '0;
        for (int i = 0; i < 16; i++) begin
            e[i*64 +: 64] = 64'hFEDC000000000000 | 64'(i);
            send("t3_d", 64'hFEDC000000000000 | 64'(i), 1'b0, 4'd0);
        end
        send("t3_l", 64'hFFFFFFFFFFFFFFFF, 1'b1, 4'd7);
        e[16*64 +: 64] = 64'h86FFFFFFFFFFFFFF;
        get_blk("t3", e, 1'b1, 2'd2, 32'd256);

        // Back-pressure: both slots fill after word 34.
        send("t4_h", hdr(2'd1, 32'd1024), 1'b0, 4'd0);
        for (int n = 1; n <= 34; n++)
            send("t4_d", {32'(n), 32'hC0DE0000 + 32'(n)}, 1'b0, 4'd0);
        chk("t4_full", 64'(s_ready), 64'd0);
        repeat (3) @(negedge clk);
        chk("t4_still_full", 64'(s_ready), 64'd0);
        e = '0;
        for (int n = 1; n <= 17; n++)
            e[(n-1)*64 +: 64] = {32'(n), 32'hC0DE0000 + 32'(n)};
        get_blk("t4a", e, 1'b0, 2'd1, 32'd1024);
        chk("t4_rdy_after_pop", 64'(s_ready), 64'd1);
        for (int n = 35; n <= 51; n++)
            send("t4_d2", {32'(n), 32'hC0DE0000 + 32'(n)}, n == 51, 4'd4);
        e = '0;
        for (int n = 18; n <= 34; n++)
            e[(n-18)*64 +: 64] = {32'(n), 32'hC0DE0000 + 32'(n)};
        get_blk("t4b", e, 1'b0, 2'd1, 32'd1024);
        e = '0;
        for (int n = 35; n <= 50; n++)
            e[(n-35)*64 +: 64] = {32'(n), 32'hC0DE0000 + 32'(n)};
        e[16*64 +: 64] = 64'h8000001FC0DE0033;
        get_blk("t4c", e, 1'b1, 2'd1, 32'd1024);

        // Message B's header accepted while A's two blocks are pending.
        send("t5_ha", hdr(2'd0, 32'd128), 1'b0, 4'd0);
        for (int n = 1; n <= 22; n++)
            send("t5_da", 64'hA000000000000000 | 64'(n), n == 22, 4'd8);
        send("t5_hb", hdr(2'd3, 32'd512), 1'b0, 4'd0);
        chk("t5_pending", 64'(blk_valid), 64'd1);
        chk("t5_data_stall", 64'(s_ready), 64'd0);
        e = '0;
        for (int n = 1; n <= 21; n++)
            e[(n-1)*64 +: 64] = 64'hA000000000000000 | 64'(n);
        get_blk("t5a1", e, 1'b0, 2'd0, 32'd128);
        send("t5_db", 64'd0, 1'b1, 4'd0);
        e = '0;
        e[63:0] = 64'hA000000000000016;
        e[8*8 +: 8] = 8'h1F;
        e[167*8 +: 8] = 8'h80;
        get_blk("t5a2", e, 1'b1, 2'd0, 32'd128);
        e = '0;
        e[7:0] = 8'h06;
        e[71*8 +: 8] = 8'h80;
        get_blk("t5b", e, 1'b1, 2'd3, 32'd512);

        // Reset in the middle of a message discards it.
        send("t6_h", hdr(2'd0, 32'd256), 1'b0, 4'd0);
        for (int n = 1; n <= 5; n++)
            send("t6_d", 64'h5500000000000000 | 64'(n), 1'b0, 4'd0);
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(blk_valid), 64'd0);
        chk("t6_rst_ready", 64'(s_ready), 64'd0);
        @(negedge clk);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_hdr_ready", 64'(s_ready), 64'd1);
        chk("t6_no_block", 64'(blk_valid), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);
        send("t6_h2", hdr(2'd1, 32'd512), 1'b0, 4'd0);
        send("t6_d2", 64'd0, 1'b1, 4'd0);
        e = '0;
        e[7:0] = 8'h1F;
        e[135*8 +: 8] = 8'h80;
        get_blk("t6", e, 1'b1, 2'd1, 32'd512);
        @(negedge clk);
        chk("t6_drained", 64'(blk_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
